pwm_capture: RTL and testbench

- Receive-side counterpart of the team's 10-bit PWM generator.
- Samples an incoming PWM waveform and measures its high time and period in clk cycles, rising edge to rising edge.
- Recovers the generator duty code, where generator high time = duty+1 cycles and period = 2^CNT_W cycles.
- Flags a stuck-high or stuck-low line. Used for loop-back self-test and for reading external PWM sources.

---
 rtl/pwm_capture_if.sv | 16 +
 rtl/pwm_capture.sv | 109 ++++++++++
 tb/tb_pwm_capture.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Measurement bus of the PWM capture block: sampled PWM line in,
// recovered high time / period / duty code and line-status flags out.
interface pwm_capture_if #(parameter int CNT_W = 10);
  logic             PWM_in;
  logic [CNT_W:0]   high_time;
  logic [CNT_W:0]   period;
  logic [CNT_W-1:0] duty_code;
  logic             meas_vld;
  logic             stuck_hi;
  logic             stuck_lo;

  modport master (input PWM_in,
                  output high_time, period, duty_code, meas_vld, stuck_hi, stuck_lo);
  modport slave  (output PWM_in,
                  input high_time, period, duty_code, meas_vld, stuck_hi, stuck_lo);
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period (rise to rise) of an async
// PWM line, recovers the generator duty code and flags a stuck line.
module pwm_capture #(
   parameter int CNT_W   = 10,
   parameter int TIMEOUT = 2047
) (
   input logic          clk,
   input logic          rst_n,
   pwm_capture_if.master bus
);
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W:0]   CNT_MAX = '1;
   localparam logic [CNT_W:0]   ONE     = 1;
   localparam logic [CNT_W-1:0] DC_ONE  = 1;
   localparam logic [TO_W-1:0]  NE_ONE  = 1;
   localparam logic [TO_W-1:0]  NE_SAT  = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0]  NE_FIRE = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t           state;
   logic             s1, s2, prev;
   logic [CNT_W:0]   p_cnt, h_cnt;
   logic [TO_W-1:0]  ne_cnt;
   logic [CNT_W:0]   high_time_r, period_r;
   logic [CNT_W-1:0] duty_code_r;
   logic             meas_vld_r, stuck_hi_r, stuck_lo_r;

   logic rise, fall, timeout;
   assign rise    = s2 & ~prev;
   assign fall    = ~s2 & prev;
   // Fires once: the counter saturates at TIMEOUT and never matches again.
   assign timeout = ~rise & ~fall & (ne_cnt == NE_FIRE);

   function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W:0] x);
      return (x == CNT_MAX) ? x : x + ONE;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         prev        <= 1'b0;
         state       <= IDLE;
         p_cnt       <= '0;
         h_cnt       <= '0;
         ne_cnt      <= '0;
         high_time_r <= '0;
         period_r    <= '0;
         duty_code_r <= '0;
         meas_vld_r  <= 1'b0;
         stuck_hi_r  <= 1'b0;
         stuck_lo_r  <= 1'b0;
      end else begin
         s1         <= bus.PWM_in;
         s2         <= s1;
         prev       <= s2;
         meas_vld_r <= 1'b0;

         if (rise || fall)
            ne_cnt <= '0;
         else if (ne_cnt != NE_SAT)
            ne_cnt <= ne_cnt + NE_ONE;

         if (timeout) begin
            state      <= IDLE;
            p_cnt      <= '0;
            h_cnt      <= '0;
            stuck_hi_r <= s2;
            stuck_lo_r <= ~s2;
         end else begin
            case (state)
               IDLE: if (rise) begin
                  // First rise after idle/stuck: start a period, nothing to report yet.
                  state      <= HIGH;
                  p_cnt      <= ONE;
                  h_cnt      <= ONE;
                  stuck_hi_r <= 1'b0;
                  stuck_lo_r <= 1'b0;
               end
               HIGH: begin
                  p_cnt <= sat_inc(p_cnt);
                  if (fall) state <= LOW;
                  else      h_cnt <= sat_inc(h_cnt);
               end
               LOW: if (rise) begin
                  state       <= HIGH;
                  period_r    <= p_cnt;
                  high_time_r <= h_cnt;
                  duty_code_r <= h_cnt[CNT_W-1:0] - DC_ONE;
                  meas_vld_r  <= 1'b1;
                  p_cnt       <= ONE;
                  h_cnt       <= ONE;
               end else begin
                  p_cnt <= sat_inc(p_cnt);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.high_time = high_time_r;
   assign bus.period    = period_r;
   assign bus.duty_code = duty_code_r;
   assign bus.meas_vld  = meas_vld_r;
   assign bus.stuck_hi  = stuck_hi_r;
   assign bus.stuck_lo  = stuck_lo_r;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: PWM waveforms driven on clk negedges,
// measurement pulses logged at negedges and compared with hand-computed values.
module tb_pwm_capture;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;

   typedef struct { int per; int hi; int dc; int cyc; } ev_t;
   ev_t ev_q[$];

   pwm_capture_if #(.CNT_W(10)) bus ();
   pwm_capture #(.CNT_W(10), .TIMEOUT(2047)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (bus.meas_vld === 1'b1) begin
      ev_q.push_back('{int'(bus.period), int'(bus.high_time), int'(bus.duty_code), cyc});
      chk("vld_no_stuck", {30'd0, bus.stuck_hi, bus.stuck_lo}, 32'd0);
   end

   // Hold the line at v for n cycles; returns just after a negedge.
   task automatic drv(input logic v, input int n);
      bus.PWM_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_ev(input string tag, input int idx, input int per, input int hi, input int dc);
      if (idx >= ev_q.size()) begin
         chk({tag, "_missing"}, ev_q.size(), idx + 1);
      end else begin
         chk({tag, "_per"}, ev_q[idx].per, per);
         chk({tag, "_hi"},  ev_q[idx].hi,  hi);
         chk({tag, "_dc"},  ev_q[idx].dc,  dc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_hi"},  bus.high_time, 0);
      chk({tag, "_per"}, bus.period, 0);
      chk({tag, "_dc"},  bus.duty_code, 0);
      chk({tag, "_vld"}, bus.meas_vld, 0);
      chk({tag, "_shi"}, bus.stuck_hi, 0);
      chk({tag, "_slo"}, bus.stuck_lo, 0);
   endtask

   initial begin
      bus.PWM_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;

      // Line low from reset: stuck_lo on the 2047th cycle.
      drv(0, 2046);
      chk("slo_early", bus.stuck_lo, 0);
      drv(0, 1);
      chk("slo_set", bus.stuck_lo, 1);
      chk("slo_shi", bus.stuck_hi, 0);
      ev_q.delete();
      repeat (3) begin drv(1, 300); drv(0, 700); end
      chk("slo_clr", bus.stuck_lo, 0);
      chk("lo_nev", ev_q.size(), 2);
      chk_ev("lo0", 0, 1000, 300, 299);
      chk_ev("lo1", 1, 1000, 300, 299);

      // Generator duty 511: first rise closes the 300/700 period.
      ev_q.delete();
      repeat (3) begin drv(1, 512); drv(0, 512); end
      chk("d511_nev", ev_q.size(), 3);
      chk_ev("d511_0", 0, 1000, 300, 299);
      chk_ev("d511_1", 1, 1024, 512, 511);
      chk_ev("d511_2", 2, 1024, 512, 511);
      if (ev_q.size() == 3) chk("d511_gap", ev_q[2].cyc - ev_q[1].cyc, 1024);
      chk("d511_stuck", {bus.stuck_hi, bus.stuck_lo}, 0);

      // Duty 1, then switch to 1000 at counter 500.
      ev_q.delete();
      drv(1, 2); drv(0, 1022);
      drv(1, 2); drv(0, 1022);
      drv(1, 2); drv(0, 498);
      drv(1, 501); drv(0, 23);
      drv(1, 1001); drv(0, 23);
      drv(1, 1001); drv(0, 23);
      chk("sw_nev", ev_q.size(), 6);
      chk_ev("sw0", 0, 1024, 512, 511);
      chk_ev("sw1", 1, 1024, 2, 1);
      chk_ev("sw2", 2, 1024, 2, 1);
      chk_ev("sw3", 3, 500, 2, 1);
      chk_ev("sw4", 4, 524, 501, 500);
      chk_ev("sw5", 5, 1024, 1001, 1000);

      // Line constant high: stuck_hi 2047 cycles after the detected rise.
      ev_q.delete();
      drv(1, 2049);
      chk("shi_early", bus.stuck_hi, 0);
      drv(1, 1);
      chk("shi_set", bus.stuck_hi, 1);
      chk("shi_slo", bus.stuck_lo, 0);
      chk("shi_vld", bus.meas_vld, 0);
      chk("shi_per", bus.period, 1024);
      chk("shi_hi", bus.high_time, 1001);
      chk("shi_dc", bus.duty_code, 1000);
      drv(1, 50);
      chk("shi_hold", bus.stuck_hi, 1);
      chk("shi_nev", ev_q.size(), 1);
      chk_ev("shi_ev", 0, 1024, 1001, 1000);

      // Recover from stuck_hi, then reset mid-HIGH.
      ev_q.delete();
      drv(0, 200); drv(1, 100); drv(0, 200);
      drv(1, 50);
      chk("rr_shi_clr", bus.stuck_hi, 0);
      chk("rr_nev", ev_q.size(), 1);
      chk_ev("rr0", 0, 300, 100, 99);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("mid_rst");
      rst_n = 1'b1;
      ev_q.delete();
      drv(1, 10); drv(0, 200); drv(1, 100); drv(0, 200); drv(1, 5);
      chk("pr_nev", ev_q.size(), 2);
      chk_ev("pr0", 0, 210, 10, 9);
      chk_ev("pr1", 1, 300, 100, 99);

      // Single-cycle pulses every 100 cycles.
      ev_q.delete();
      drv(0, 99);
      repeat (4) begin drv(1, 1); drv(0, 99); end
      chk("gl_nev", ev_q.size(), 4);
      chk_ev("gl0", 0, 104, 5, 4);
      chk_ev("gl1", 1, 100, 1, 0);
      chk_ev("gl3", 3, 100, 1, 0);
      chk("gl_stuck", {bus.stuck_hi, bus.stuck_lo}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
